intra_block_scheduler: RTL
==========================

// Module: intra_block_scheduler
// PURPOSE
// Wavefront dispatcher sharing one frame of intra blocks among NUM_ENG intraloop engines.
// Engine e owns rows e, e+NUM_ENG, ... and walks each row left to right, one block at a time.
// A block (c,r) issues only after left (c-1,r) and above-right (c+1,r-1) are reconstructed.
// Replaces free-running per-engine mbnumber stepping with one synchronous, checkable sequencer.
// PARAMETERS
// NUM_ENG  2     engines served (>=1)
// FRAME_W  1280  frame width, pixels (multiple of BLK)
// FRAME_H  720   frame height, pixels (multiple of BLK)
// BLK      4     block edge, pixels (4 luma 4x4, 8 chroma 8x8)
// Derived: COLS=FRAME_W/BLK, ROWS=FRAME_H/BLK
// PORTS
// clk        in   1          clock
// reset      in   1          asynchronous, active-low reset
// start      in   1          frame start pulse; ignored while busy
// eng_start  out  NUM_ENG    1-cycle pulse: engine e begins block at eng_coord[e]
// eng_coord  out  NUM_ENG*32 per engine {y[15:0],x[15:0]} pixel origin; held until next eng_start
// eng_done   in   NUM_ENG    1-cycle pulse: engine e finished/reconstructed its block
// busy       out  1          frame in progress
// frame_done out  1          1-cycle pulse when every engine has finished
// proto_err  out  1          sticky: eng_done[e] seen while lane e not BUSY
// blk_count  out  32         blocks completed this frame
// BEHAVIOUR
// - Reset: all outputs 0, every lane IDLE, counters 0. Reset mid-frame aborts immediately.
// - Lane FSM per engine: IDLE -> WAIT -> BUSY -> WAIT ... -> FIN -> IDLE.
// - start sampled at edge T while !busy: busy=1, blk_count=0, lane e: row=e, col=0, cnt=0;
//   WAIT if e<ROWS, else FIN directly.
// - WAIT, dependency met: eng_start[e]=1 for one cycle, eng_coord[e]={row*BLK,col*BLK}, -> BUSY.
//   Row 0 first block: eng_start[0] high in the cycle after edge T+1.
// - Dependency, row r>0, pred p=(e+NUM_ENG-1)%NUM_ENG: met iff lane p FIN, or row_p>r-1,
//   or (row_p==r-1 and cnt_p >= min(col+2,COLS)). Row 0 always met. Left neighbour is implicit.
// - Checks use registered state: a pred done at edge T unblocks at edge T+1 at earliest.
// - BUSY, eng_done[e]: cnt++, blk_count++. If col==COLS-1: row+=NUM_ENG, col=0, cnt=0,
//   -> FIN if row>=ROWS else WAIT. Otherwise col++, -> WAIT.
// - eng_done in the eng_start cycle is legal (lane already BUSY on that edge).
// - Minimum gap between done and the next eng_start on one lane: 1 idle cycle.
// - Edge where the last lane enters FIN: frame_done=1 (one cycle), busy=0, lanes -> IDLE.
// - eng_done while IDLE/WAIT/FIN: ignored for counting, proto_err=1 until reset.
// - Simultaneous dones on several lanes all accepted in one cycle; blk_count adds popcount.
// - start coinciding with frame_done edge: ignored (busy still 1 that edge).
// - row/col/cnt 16-bit unsigned; coord multiply by BLK is a constant shift/mult, truncated to 16.
// STRUCTURE
// - Package intra_sched_pkg: lane_state_t enum {IDLE,WAIT,BUSY,FIN}, coord pack function
//   {y,x}->32b.
// - Sub-module intra_sched_lane: one lane FSM + row/col/cnt; inputs pred row/cnt/fin; generated
//   NUM_ENG times.
// - Top: start/busy control, lane generate loop, all-FIN detect, blk_count adder, proto_err.
// TESTING (engine model: done N cycles after eng_start)
// 1 NUM_ENG=1,FRAME 16x8,BLK 4: start -> coords (0,0),(0,4),(0,8),(0,12),(4,0)..(4,12) as {y,x};
//   frame_done once, blk_count=8.
// 2 NUM_ENG=2,FRAME 16x8, eng latency 5: eng_start[1] at {4,0} only after lane0 cnt=2;
//   never earlier; blk_count=8.
// 3 Reset low mid-frame (lane0 BUSY at col 2): all outputs 0 next cycle; new start restarts at {0,0}.
// 4 start pulsed while busy -> no effect on coords or counts; frame completes normally.
// 5 eng_done[1] pulsed while lane1 WAIT -> proto_err=1, blk_count unchanged, frame still completes.
// 6 NUM_ENG=3,FRAME 8x8 (2 rows): lane2 FIN at start, never eng_start[2]; frame_done after 4 blocks.

Source files
------------

// File: rtl/intra_sched_pkg.sv
// Shared types for the intra block wavefront scheduler.
// Lane state encoding and coordinate packing helper.
package intra_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    BUSY,
    FIN
  } lane_state_t;

  function automatic logic [31:0] pack_coord(
    input logic [15:0] y,
    input logic [15:0] x
  );
    return {y, x};
  endfunction

endpackage

// File: rtl/intra_sched_lane.sv
// One engine lane: walks its rows left to right, issuing a block
// once the left and above-right neighbours are reconstructed.
module intra_sched_lane
  import intra_sched_pkg::*;
#(
  parameter int NUM_ENG = 2,
  parameter int ROWS    = 180,
  parameter int COLS    = 320,
  parameter int BLK     = 4,
  parameter int LANE    = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        go,
  input  logic        clr,
  input  logic        done,
  input  logic [15:0] pred_row,
  input  logic [15:0] pred_cnt,
  input  logic        pred_fin,
  output logic [15:0] row,
  output logic [15:0] cnt,
  output logic        fin,
  output logic        active,
  output logic        fin_next,
  output logic        issue,
  output logic [31:0] coord
);

  localparam logic [15:0] BLK16  = 16'(BLK);
  localparam logic [15:0] LAST   = 16'(COLS - 1);
  localparam logic [15:0] FIRST  = 16'(LANE);
  localparam logic [16:0] COLS17 = 17'(COLS);
  localparam logic [16:0] ROWS17 = 17'(ROWS);
  localparam logic [16:0] STEP17 = 17'(NUM_ENG);

  lane_state_t state, state_d;
  logic [15:0] col, row_d, col_d, cnt_d;
  logic [16:0] ahead, need, row_sum;
  logic        dep_ok, above, issue_d;
  logic [31:0] coord_d;

  always_comb begin
    ahead   = {1'b0, col} + 17'd2;
    need    = (ahead > COLS17) ? COLS17 : ahead;
    row_sum = {1'b0, row} + STEP17;
    above   = row - 16'd1 == pred_row;
    // pred lane owns row-1; its cnt says how far along that row it is
    dep_ok  = (row == 16'd0)
           || pred_fin
           || (pred_row > row - 16'd1)
           || (above && {1'b0, pred_cnt} >= need);

    state_d = state;
    row_d   = row;
    col_d   = col;
    cnt_d   = cnt;
    issue_d = 1'b0;
    coord_d = coord;

    unique case (state)
      IDLE: begin
        if (go) begin
          row_d   = FIRST;
          col_d   = '0;
          cnt_d   = '0;
          state_d = (LANE < ROWS) ? WAIT : FIN;
        end
      end
      WAIT: begin
        if (dep_ok) begin
          issue_d = 1'b1;
          coord_d = pack_coord(row * BLK16, col * BLK16);
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          cnt_d = cnt + 16'd1;
          if (col == LAST) begin
            row_d   = row_sum[15:0];
            col_d   = '0;
            cnt_d   = '0;
            state_d = (row_sum >= ROWS17) ? FIN : WAIT;
          end else begin
            col_d   = col + 16'd1;
            state_d = WAIT;
          end
        end
      end
      FIN: ;
      default: state_d = IDLE;
    endcase

    fin_next = state_d == FIN;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      row   <= '0;
      col   <= '0;
      cnt   <= '0;
      issue <= 1'b0;
      coord <= '0;
    end else begin
      state <= clr ? IDLE : state_d;
      row   <= row_d;
      col   <= col_d;
      cnt   <= cnt_d;
      issue <= issue_d;
      coord <= coord_d;
    end
  end

  assign fin    = state == FIN;
  assign active = state == BUSY;

endmodule

// File: rtl/intra_block_scheduler.sv
// Wavefront dispatcher sharing one frame of intra blocks
// among NUM_ENG engines, one row-interleaved lane per engine.
module intra_block_scheduler
  import intra_sched_pkg::*;
#(
  parameter int NUM_ENG = 2,
  parameter int FRAME_W = 1280,
  parameter int FRAME_H = 720,
  parameter int BLK     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  output logic [NUM_ENG-1:0]    eng_start,
  output logic [NUM_ENG*32-1:0] eng_coord,
  input  logic [NUM_ENG-1:0]    eng_done,
  output logic                  busy,
  output logic                  frame_done,
  output logic                  proto_err,
  output logic [31:0]           blk_count
);

  localparam int COLS = FRAME_W / BLK;
  localparam int ROWS = FRAME_H / BLK;

  logic               go, all_fin;
  logic [NUM_ENG-1:0] fin, active, fin_next, took;
  logic [15:0]        row_q [NUM_ENG];
  logic [15:0]        cnt_q [NUM_ENG];
  logic [31:0]        inc;

  assign go      = start & ~busy;
  assign all_fin = busy & (&fin_next);
  assign took    = eng_done & active;

  for (genvar e = 0; e < NUM_ENG; e++) begin : g_lane
    localparam int P = (e + NUM_ENG - 1) % NUM_ENG;
    intra_sched_lane #(
      .NUM_ENG (NUM_ENG),
      .ROWS    (ROWS),
      .COLS    (COLS),
      .BLK     (BLK),
      .LANE    (e)
    ) u_lane (
      .clk      (clk),
      .reset    (reset),
      .go       (go),
      .clr      (all_fin),
      .done     (eng_done[e]),
      .pred_row (row_q[P]),
      .pred_cnt (cnt_q[P]),
      .pred_fin (fin[P]),
      .row      (row_q[e]),
      .cnt      (cnt_q[e]),
      .fin      (fin[e]),
      .active   (active[e]),
      .fin_next (fin_next[e]),
      .issue    (eng_start[e]),
      .coord    (eng_coord[e*32 +: 32])
    );
  end

  always_comb begin
    inc = '0;
    for (int i = 0; i < NUM_ENG; i++) begin
      inc = inc + 32'(took[i]);
    end
  end

  // last lane reaching FIN ends the frame on that same edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy       <= 1'b0;
      frame_done <= 1'b0;
      proto_err  <= 1'b0;
      blk_count  <= '0;
    end else begin
      frame_done <= all_fin;
      proto_err  <= proto_err | (|(eng_done & ~active));
      if (go) begin
        busy      <= 1'b1;
        blk_count <= '0;
      end else begin
        blk_count <= blk_count + inc;
        if (all_fin) busy <= 1'b0;
      end
    end
  end

endmodule
